// File: rtl/hdr_ddr_tx_engine.sv
`default_nettype none
// ============================================================================
// Module : hdr_ddr_tx_engine
// Brief  : HDR-DDR transmit sequencer: command word, prefetched data words and
//          CRC word serialised onto SDA, one bit per SCL-generator tick.
// Rev    : 1.0  initial release
// ============================================================================
module hdr_ddr_tx_engine #(
  parameter int          ADDR_W   = 8,
  parameter int          CNT_W    = 8,
  parameter logic [4:0]  CRC_INIT = 5'h1F
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_ddrmode_en,
  input  logic              i_bit_tick,
  input  logic              i_rnw,
  input  logic [6:0]        i_cmd_code,
  input  logic [6:0]        i_tgt_addr,
  input  logic [CNT_W-1:0]  i_byte_count,
  input  logic [ADDR_W-1:0] i_regf_base_addr,
  input  logic [7:0]        i_regf_data,
  output logic              o_regf_rd_en,
  output logic [ADDR_W-1:0] o_regf_addr,
  output logic              o_sda_bit,
  output logic              o_sda_oe,
  output logic              o_ddr_mode_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_CMD = 3'd1,
    S_SH_CMD   = 3'd2,
    S_SH_DATA  = 3'd3,
    S_SH_CRC   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                en_q;
  logic                rnw_q, rnw_d;
  logic [6:0]          cmd_q, cmd_d, tgt_q, tgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
  logic [19:0]         sh_q, sh_d;
  logic [4:0]          bidx_q, bidx_d, len_q, len_d;
  logic                sda_q, sda_d, oe_q, oe_d;
  logic                rd_en_q, rd_en_d, pf2_q, pf2_d, lo_q, lo_d;
  logic                rv_q, rv_d, rlo_q, rlo_d;
  logic [15:0]         nxt_q, nxt_d;
  logic                nxt_vld_q, nxt_vld_d;
  logic [4:0]          crc_q, crc_d;
  logic                pf_start;
  logic [19:0]         word;
  logic [15:0]         cmd_dw;

  function automatic logic [19:0] mk_word(input logic [1:0] pre, input logic [15:0] d);
    return {pre, d, ^(d & 16'hAAAA), ~(^(d & 16'h5555))};
  endfunction

  // x^5+x^2+1, MSB-first over one 16-bit data payload
  function automatic logic [4:0] crc_upd(input logic [4:0] c, input logic [15:0] d);
    logic [4:0] r;
    logic       fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[4] ^ d[i];
      r  = {r[3:0], 1'b0} ^ {2'b00, fb, 1'b0, fb};
    end
    return r;
  endfunction

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= S_IDLE;   en_q    <= 1'b0;  rnw_q  <= 1'b0;
      cmd_q   <= '0;       tgt_q   <= '0;    cnt_q  <= '0;    fcnt_q <= '0;
      base_q  <= '0;       addr_q  <= '0;    sh_q   <= '0;
      bidx_q  <= '0;       len_q   <= '0;    sda_q  <= 1'b0;  oe_q   <= 1'b0;
      rd_en_q <= 1'b0;     pf2_q   <= 1'b0;  lo_q   <= 1'b0;
      rv_q    <= 1'b0;     rlo_q   <= 1'b0;  nxt_q  <= '0;    nxt_vld_q <= 1'b0;
      crc_q   <= CRC_INIT;
    end else begin
      state_q <= state_d;  en_q    <= i_ddrmode_en;  rnw_q <= rnw_d;
      cmd_q   <= cmd_d;    tgt_q   <= tgt_d;   cnt_q  <= cnt_d;   fcnt_q <= fcnt_d;
      base_q  <= base_d;   addr_q  <= addr_d;  sh_q   <= sh_d;
      bidx_q  <= bidx_d;   len_q   <= len_d;   sda_q  <= sda_d;   oe_q   <= oe_d;
      rd_en_q <= rd_en_d;  pf2_q   <= pf2_d;   lo_q   <= lo_d;
      rv_q    <= rv_d;     rlo_q   <= rlo_d;   nxt_q  <= nxt_d;   nxt_vld_q <= nxt_vld_d;
      crc_q   <= crc_d;
    end
  end

  assign cmd_dw = {rnw_q, cmd_q, tgt_q, ^({rnw_q, cmd_q, tgt_q, 1'b0} & 16'h5554)};

  always_comb begin
    state_d = state_q;  rnw_d = rnw_q;  cmd_d = cmd_q;  tgt_d = tgt_q;
    cnt_d   = cnt_q;    fcnt_d = fcnt_q; base_d = base_q; addr_d = addr_q;
    sh_d    = sh_q;     bidx_d = bidx_q; len_d = len_q;  sda_d = sda_q;  oe_d = oe_q;
    rd_en_d = 1'b0;     pf2_d = pf2_q;  lo_d = lo_q;
    rv_d    = rd_en_q;  rlo_d = lo_q;   nxt_d = nxt_q;  nxt_vld_d = nxt_vld_q;
    crc_d   = crc_q;    pf_start = 1'b0; word = '0;

    // Read data lands one clock after the strobe; the low byte is the second read
    if (rv_q) begin
      if (rlo_q) nxt_d[7:0]  = i_regf_data;
      else       nxt_d[15:8] = i_regf_data;
    end
    if (pf2_q) begin
      rd_en_d = 1'b1;
      addr_d  = base_q + ADDR_W'(fcnt_q);
      fcnt_d  = fcnt_q + CNT_W'(1);
      pf2_d   = 1'b0;
      lo_d    = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_ddrmode_en && !en_q) begin
          rnw_d = i_rnw;  cmd_d = i_cmd_code;  tgt_d = i_tgt_addr;
          cnt_d = i_byte_count;  base_d = i_regf_base_addr;
          fcnt_d = '0;  crc_d = CRC_INIT;  nxt_vld_d = 1'b0;
          state_d = S_LOAD_CMD;
        end
      end
      S_LOAD_CMD: begin
        sh_d = mk_word(2'b01, cmd_dw);
        bidx_d = '0;  len_d = 5'd20;
        pf_start = 1'b1;
        state_d = S_SH_CMD;
      end
      S_SH_CMD, S_SH_DATA, S_SH_CRC: begin
        if (i_bit_tick) begin
          if (bidx_q != len_q) begin
            sda_d = sh_q[19];  sh_d = {sh_q[18:0], 1'b0};
            bidx_d = bidx_q + 5'd1;  oe_d = 1'b1;
          end else if (nxt_vld_q) begin
            word = mk_word(2'b10, nxt_q);
            sda_d = word[19];  sh_d = {word[18:0], 1'b0};
            bidx_d = 5'd1;  len_d = 5'd20;  oe_d = 1'b1;
            crc_d = crc_upd(crc_q, nxt_q);
            nxt_vld_d = 1'b0;  pf_start = 1'b1;
            state_d = S_SH_DATA;
          end else if (state_q == S_SH_DATA) begin
            word = {9'd0, 2'b01, 4'hC, crc_q};
            sda_d = word[10];  sh_d = {word[9:0], 10'd0};
            bidx_d = 5'd1;  len_d = 5'd11;  oe_d = 1'b1;
            state_d = S_SH_CRC;
          end else begin
            sda_d = 1'b0;  oe_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        oe_d = 1'b0;  sda_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pf_start && !rnw_q && (fcnt_q < cnt_q)) begin
      rd_en_d   = 1'b1;
      addr_d    = base_q + ADDR_W'(fcnt_q);
      fcnt_d    = fcnt_q + CNT_W'(1);
      pf2_d     = (fcnt_q + CNT_W'(1)) < cnt_q;
      lo_d      = 1'b0;
      nxt_d     = '0;
      nxt_vld_d = 1'b1;
    end

    // Enable loss wins over everything, including a coincident tick
    if (state_q != S_IDLE && !i_ddrmode_en) begin
      state_d = S_IDLE;  oe_d = 1'b0;  sda_d = 1'b0;
      rd_en_d = 1'b0;  pf2_d = 1'b0;  rv_d = 1'b0;
      nxt_vld_d = 1'b0;  crc_d = CRC_INIT;
    end
  end

  assign o_regf_rd_en    = rd_en_q;
  assign o_regf_addr     = addr_q;
  assign o_sda_bit       = sda_q;
  assign o_sda_oe        = oe_q;
  assign o_ddr_mode_done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hdr_ddr_tx_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_hdr_ddr_tx_engine
// Brief  : Directed bench with a bit-level SDA scoreboard and read-address queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hdr_ddr_tx_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, tick = 1'b0, rnw = 1'b0;
  logic [6:0] cmd = '0, tgt = '0;
  logic [7:0] cnt = '0, base = '0, regf_data = '0;
  logic       rd_en, sda, oe, done;
  logic [7:0] raddr;

  logic [7:0] mem [256];
  logic       exp_bits [$];
  logic [7:0] exp_addr [$];
  int         assert_cnt = 0, fail_cnt = 0, done_cnt = 0;

  hdr_ddr_tx_engine #(.ADDR_W(8), .CNT_W(8), .CRC_INIT(5'h1F)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_ddrmode_en(en), .i_bit_tick(tick),
    .i_rnw(rnw), .i_cmd_code(cmd), .i_tgt_addr(tgt), .i_byte_count(cnt),
    .i_regf_base_addr(base), .i_regf_data(regf_data), .o_regf_rd_en(rd_en),
    .o_regf_addr(raddr), .o_sda_bit(sda), .o_sda_oe(oe), .o_ddr_mode_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) regf_data <= mem[raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (rd_en) begin
        if (exp_addr.size() == 0) chk("rd_unexpected", {31'd0, rd_en}, 32'd0);
        else                      chk("rd_addr", {24'd0, raddr}, {24'd0, exp_addr.pop_front()});
      end
    end
  end

  task automatic push_bits(input logic [19:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bits.push_back(w[i]);
  endtask

  function automatic logic [19:0] ref_word(input logic [1:0] pre, input logic [15:0] d);
    logic p1, p0;
    p1 = 1'b0;  p0 = 1'b1;
    for (int i = 1; i < 16; i += 2) p1 ^= d[i];
    for (int i = 0; i < 16; i += 2) p0 ^= d[i];
    return {pre, d, p1, p0};
  endfunction

  task automatic do_tick();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic build_expect(input logic r, input logic [6:0] c, input logic [6:0] t,
                              input logic [7:0] n, input logic [7:0] b);
    logic [15:0] d;
    logic [4:0]  crc;
    logic [7:0]  a;
    logic        fb;
    exp_bits.delete();
    exp_addr.delete();
    d = {r, c, t, 1'b0};
    for (int i = 2; i <= 14; i += 2) d[0] ^= d[i];
    push_bits(ref_word(2'b01, d), 20);
    if (!r && n != 0) begin
      crc = 5'h1F;
      for (int j = 0; 2 * j < int'(n); j++) begin
        a = b + 8'(2 * j);
        d[15:8] = mem[a];
        a = a + 8'd1;
        d[7:0] = (2 * j + 1 < int'(n)) ? mem[a] : 8'h00;
        push_bits(ref_word(2'b10, d), 20);
        for (int i = 15; i >= 0; i--) begin
          fb  = crc[4] ^ d[i];
          crc = {crc[3:0], 1'b0};
          if (fb) crc = crc ^ 5'h05;
        end
      end
      for (int i = 0; i < int'(n); i++) exp_addr.push_back(b + 8'(i));
      push_bits({9'd0, 2'b01, 4'hC, crc}, 11);
    end
  endtask

  // abort_at < 0: full transfer; otherwise en drops after that many bits
  task automatic run_xfer(input logic r, input logic [6:0] c, input logic [6:0] t,
                          input logic [7:0] n, input logic [7:0] b, input int abort_at);
    int nb, d0;
    build_expect(r, c, t, n, b);
    nb = exp_bits.size();
    d0 = done_cnt;
    rnw = r;  cmd = c;  tgt = t;  cnt = n;  base = b;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    // later input changes must not affect the latched transfer
    cnt = 8'h55;  base = 8'h77;  cmd = ~c;
    for (int k = 0; k < nb; k++) begin
      if (k == abort_at) begin
        en = 1'b0;
        @(negedge clk);
        chk("abort_oe", {31'd0, oe}, 32'd0);
        chk("abort_rd", {31'd0, rd_en}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        exp_bits.delete();
        exp_addr.delete();
        return;
      end
      do_tick();
      chk($sformatf("oe_bit%0d", k), {31'd0, oe}, 32'd1);
      chk($sformatf("sda_bit%0d", k), {31'd0, sda}, {31'd0, exp_bits.pop_front()});
    end
    do_tick();
    chk("end_oe", {31'd0, oe}, 32'd0);
    chk("end_done", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, d0 + 1);
    chk("reads_left", exp_addr.size(), 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    repeat (2) @(negedge clk);
    chk("rst_oe", {31'd0, oe}, 32'd0);
    chk("rst_sda", {31'd0, sda}, 32'd0);
    chk("rst_rd", {31'd0, rd_en}, 32'd0);
    chk("rst_addr", {24'd0, raddr}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ticks while idle do nothing
    for (int i = 0; i < 3; i++) do_tick();
    chk("idle_oe", {31'd0, oe}, 32'd0);

    mem[8'h10] = 8'hA5;  mem[8'h11] = 8'h5A;
    run_xfer(1'b0, 7'h20, 7'h08, 8'd2, 8'h10, -1);
    run_xfer(1'b1, 7'h20, 7'h08, 8'd2, 8'h10, -1);
    mem[8'hFE] = 8'h11;  mem[8'hFF] = 8'h22;  mem[8'h00] = 8'h33;
    run_xfer(1'b0, 7'h31, 7'h52, 8'd3, 8'hFE, -1);
    run_xfer(1'b0, 7'h20, 7'h08, 8'd0, 8'h10, -1);
    run_xfer(1'b0, 7'h2A, 7'h15, 8'd1, 8'h40, -1);
    run_xfer(1'b0, 7'h44, 7'h33, 8'd4, 8'h80, 30);
    run_xfer(1'b0, 7'h44, 7'h33, 8'd4, 8'h80, -1);
    run_xfer(1'b0, 7'h7F, 7'h7E, 8'd8, 8'hC0, -1);

    // asynchronous reset in the middle of a read command
    build_expect(1'b1, 7'h20, 7'h08, 8'd0, 8'h00);
    rnw = 1'b1;  cmd = 7'h20;  tgt = 7'h08;  cnt = 8'd0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) do_tick();
    chk("pre_rst_oe", {31'd0, oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_oe", {31'd0, oe}, 32'd0);
    chk("async_sda", {31'd0, sda}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_bits.delete();
    run_xfer(1'b0, 7'h20, 7'h08, 8'd2, 8'h10, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
